// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared constants, word type and state encoding for the fetch stage.
//  Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC  = 16'h0000;
    localparam word_t NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_VALID  = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Brief    : Instruction-memory bus plus decode/execute handshake of fetch.
//  Revision : 1.0
// ============================================================================
interface fetch_if;
    import fetch_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    word_t imem_rdata;
    logic  imem_done;
    logic  imem_err;
    logic  stall_in;
    logic  halt_in;
    logic  redirect;
    word_t redirect_pc;
    logic  instr_valid;
    word_t instr_out;
    word_t pc_out;
    word_t pc_plus2_out;
    logic  halted;
    logic  err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, pc_out,
               pc_plus2_out, halted, err,
        input  imem_rdata, imem_done, imem_err, stall_in, halt_in,
               redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
               pc_plus2_out, halted, err,
        output imem_rdata, imem_done, imem_err, stall_in, halt_in,
               redirect, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_reg16_en.sv
`default_nettype none
// ============================================================================
//  Module   : reg16_en
//  Brief    : 16-bit register with load enable and synchronous reset value.
//  Revision : 1.0
// ============================================================================
module reg16_en
    import fetch_pkg::*;
#(
    parameter word_t RST_VAL = 16'h0000
) (
    input  wire   clk,
    input  wire   rst,
    input  wire   i_en,
    input  word_t i_d,
    output word_t o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Brief    : Instruction-fetch stage: PC ownership, imem reads, redirect
//             squashing and halt parking, feeding decode via valid/stall.
//  Revision : 1.0
// ============================================================================
module fetch
    import fetch_pkg::*;
(
    input  wire      clk,
    input  wire      rst,
    fetch_if.master  bus
);

    state_t r_state;
    state_t w_state_nxt;
    word_t  r_pc;
    word_t  r_req_addr;
    word_t  r_instr;
    word_t  r_pc_out;
    word_t  r_pc_plus2;
    logic   r_err;

    logic   w_consume;
    logic   w_req;
    word_t  w_addr;
    word_t  w_addr_p2;
    logic   w_pc_en;
    word_t  w_pc_d;
    logic   w_ra_en;
    word_t  w_ra_d;
    logic   w_cap;
    logic   w_err_set;

    assign w_consume = (r_state == ST_VALID) & ~bus.stall_in;
    assign w_addr_p2 = w_addr + 16'd2;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_req_addr;
        w_pc_en     = 1'b0;
        w_pc_d      = r_pc;
        w_ra_en     = 1'b0;
        w_ra_d      = r_req_addr;
        w_cap       = 1'b0;
        w_err_set   = 1'b0;

        // A new read from VALID is only launched when it cannot be abandoned
        // in the same cycle, so the request/address hold rule is never broken.
        case (r_state)
            ST_FETCH, ST_SQUASH: w_req = 1'b1;
            ST_VALID: begin
                w_addr = r_pc;
                w_req  = w_consume & ~bus.halt_in & ~bus.redirect;
            end
            default: w_req = 1'b0;
        endcase

        if (r_state == ST_HALTED) begin
            w_state_nxt = ST_HALTED;
        end else if (bus.redirect) begin
            if (bus.redirect_pc[0]) begin
                w_err_set   = 1'b1;
                w_state_nxt = ST_HALTED;
            end else begin
                w_pc_en = 1'b1;
                w_pc_d  = bus.redirect_pc;
                if ((r_state == ST_VALID) || bus.imem_done) begin
                    w_ra_en     = 1'b1;
                    w_ra_d      = bus.redirect_pc;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_SQUASH;
                end
            end
        end else if (w_consume && bus.halt_in) begin
            w_state_nxt = ST_HALTED;
        end else if (w_req && bus.imem_done) begin
            if (r_state == ST_SQUASH) begin
                w_ra_en     = 1'b1;
                w_ra_d      = r_pc;
                w_state_nxt = ST_FETCH;
            end else if (bus.imem_err) begin
                w_err_set   = 1'b1;
                w_state_nxt = ST_HALTED;
            end else begin
                w_cap       = 1'b1;
                w_pc_en     = 1'b1;
                w_pc_d      = w_addr_p2;
                w_ra_en     = 1'b1;
                w_ra_d      = w_addr;
                w_state_nxt = ST_VALID;
            end
        end else if (w_req && (r_state == ST_VALID)) begin
            w_ra_en     = 1'b1;
            w_ra_d      = r_pc;
            w_state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    reg16_en #(.RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .i_en(w_pc_en), .i_d(w_pc_d), .o_q(r_pc)
    );

    reg16_en #(.RST_VAL(RESET_PC)) u_req_addr (
        .clk(clk), .rst(rst), .i_en(w_ra_en), .i_d(w_ra_d), .o_q(r_req_addr)
    );

    reg16_en #(.RST_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .i_en(w_cap), .i_d(bus.imem_rdata), .o_q(r_instr)
    );

    reg16_en #(.RST_VAL(RESET_PC)) u_pc_out (
        .clk(clk), .rst(rst), .i_en(w_cap), .i_d(w_addr), .o_q(r_pc_out)
    );

    reg16_en #(.RST_VAL(RESET_PC + 16'd2)) u_pc_plus2 (
        .clk(clk), .rst(rst), .i_en(w_cap), .i_d(w_addr_p2), .o_q(r_pc_plus2)
    );

    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = w_addr;
    assign bus.instr_valid  = (r_state == ST_VALID);
    assign bus.instr_out    = (r_state == ST_VALID) ? r_instr : NOP_INSTR;
    assign bus.pc_out       = r_pc_out;
    assign bus.pc_plus2_out = r_pc_plus2;
    assign bus.halted       = (r_state == ST_HALTED);
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Brief    : Self-checking bench for fetch: memory responder, program-order
//             scoreboard, directed scenarios and a randomized phase.
//  Revision : 1.0
// ============================================================================
module tb_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_if bus ();

    fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // stimulus knobs
    logic        k_stall = 1'b0, k_halt = 1'b0, k_redir = 1'b0, k_inj = 1'b0;
    logic [15:0] k_rpc   = 16'h0000;
    int          k_lat   = 0;

    // memory responder
    logic        m_pend = 1'b0;
    int          m_cnt  = 0, m_lat = 0;
    logic [15:0] m_addr = 16'h0000;

    // program-order model
    logic [15:0] exp_pc = 16'h0000, prev_pc = 16'h0000, prev_instr = 16'h0000;
    logic        sb_halt = 1'b0, err_exp = 1'b0, prev_redir = 1'b0, prev_hold = 1'b0;

    // sampled outputs
    logic        obs_req, obs_valid, obs_halted, obs_err;
    logic [15:0] obs_addr, obs_instr, obs_pc, obs_pc2;
    logic [15:0] cap_pc, cap_instr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        k_stall = 1'b0; k_halt = 1'b0; k_redir = 1'b0; k_inj = 1'b0;
        bus.stall_in = 1'b0; bus.halt_in = 1'b0; bus.redirect = 1'b0;
        bus.imem_done = 1'b0; bus.imem_err = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        exp_pc     = RESET_PC;
        sb_halt    = 1'b0;
        err_exp    = 1'b0;
        prev_redir = 1'b0;
        prev_hold  = 1'b0;
        m_pend     = 1'b0;
    endtask

    // One clock cycle: drive, answer memory, sample, score, advance.
    task automatic step();
        logic        done, halt_n, err_n;
        logic [15:0] e2;
        bus.stall_in    = k_stall;
        bus.redirect    = k_redir;
        bus.redirect_pc = k_rpc;
        bus.halt_in     = 1'b0;
        bus.imem_done   = 1'b0;
        bus.imem_err    = 1'b0;
        #1;
        bus.halt_in = k_halt & bus.instr_valid & ~k_stall;
        #1;
        done = 1'b0;
        if (bus.imem_req) begin
            if (!m_pend) begin
                m_pend = 1'b1; m_cnt = 0; m_lat = k_lat; m_addr = bus.imem_addr;
            end else begin
                check("addr_stable", bus.imem_addr, m_addr);
            end
            done = (m_cnt >= m_lat);
        end else if (m_pend && !sb_halt) begin
            check("req_held", bus.imem_req, 1'b1);
        end
        bus.imem_done  = done;
        bus.imem_rdata = mem_word(bus.imem_addr);
        bus.imem_err   = done & k_inj;
        #1;
        obs_req = bus.imem_req;     obs_addr  = bus.imem_addr;
        obs_valid = bus.instr_valid; obs_instr = bus.instr_out;
        obs_pc = bus.pc_out;         obs_pc2   = bus.pc_plus2_out;
        obs_halted = bus.halted;     obs_err   = bus.err;

        halt_n = sb_halt;
        err_n  = err_exp;
        check("halted", obs_halted, sb_halt);
        check("err", obs_err, err_exp);
        if (sb_halt) begin
            check("halt_req", obs_req, 1'b0);
            check("halt_valid", obs_valid, 1'b0);
        end else begin
            if (prev_redir) check("redir_valid", obs_valid, 1'b0);
            if (prev_hold) begin
                check("stall_valid", obs_valid, 1'b1);
                check("stall_pc", obs_pc, prev_pc);
                check("stall_instr", obs_instr, prev_instr);
            end
            if (!obs_valid) check("nop", obs_instr, NOP_INSTR);
            if (obs_valid && k_stall) check("stall_req", obs_req, 1'b0);
            if (obs_valid && !k_stall) begin
                e2 = exp_pc + 16'd2;
                check("pc", obs_pc, exp_pc);
                check("instr", obs_instr, mem_word(exp_pc));
                check("pc2", obs_pc2, e2);
                exp_pc = e2;
                if (bus.halt_in && !k_redir) halt_n = 1'b1;
            end
            if (done && k_inj) begin
                err_n = 1'b1; halt_n = 1'b1;
            end
            if (k_redir) begin
                if (k_rpc[0]) begin
                    err_n = 1'b1; halt_n = 1'b1;
                end else begin
                    exp_pc = k_rpc;
                end
            end
        end
        prev_redir = k_redir && !sb_halt;
        prev_hold  = obs_valid && k_stall && !k_redir && !sb_halt;
        prev_pc    = obs_pc;
        prev_instr = obs_instr;
        sb_halt    = halt_n;
        err_exp    = err_n;
        if (done) m_pend = 1'b0;
        else if (m_pend) m_cnt++;
        if (sb_halt) m_pend = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_until_valid(input string tag);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!obs_valid && i < 20);
        check(tag, obs_valid, 1'b1);
    endtask

    initial begin
        bus.stall_in = 1'b0; bus.halt_in = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000; bus.imem_done = 1'b0; bus.imem_err = 1'b0;
        bus.imem_rdata = 16'h0000;
        @(negedge clk);
        do_reset();

        // reset state and zero-wait streaming
        step();
        check("rst_valid", obs_valid, 1'b0);
        check("rst_pc", obs_pc, RESET_PC);
        check("rst_pc2", obs_pc2, 16'h0002);
        check("rst_req", obs_req, 1'b1);
        check("rst_addr", obs_addr, RESET_PC);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("zw_addr", obs_addr, 32'(2 * i));
            check("zw_valid", obs_valid, 1'b1);
        end

        // 3-cycle read at 0x0010
        k_redir = 1'b1; k_rpc = 16'h0010; k_lat = 2;
        step();
        k_redir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lat_addr", obs_addr, 16'h0010);
            check("lat_req", obs_req, 1'b1);
        end
        step();
        check("lat_valid", obs_valid, 1'b1);
        check("lat_pc", obs_pc, 16'h0010);

        // stall held in VALID for 4 cycles
        k_lat = 0; k_stall = 1'b1;
        run_until_valid("stall_wait");
        cap_pc = obs_pc; cap_instr = obs_instr;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_pc", obs_pc, cap_pc);
            check("st_instr", obs_instr, cap_instr);
            check("st_req", obs_req, 1'b0);
        end
        k_stall = 1'b0;
        step();
        check("st_rel_req", obs_req, 1'b1);
        check("st_rel_addr", obs_addr, cap_pc + 16'd2);

        // redirect while 2-cycle read of 0x0040 outstanding
        k_lat = 1; k_redir = 1'b1; k_rpc = 16'h0040;
        step();
        k_rpc = 16'h0100;
        step();
        check("sq_addr", obs_addr, 16'h0040);
        k_redir = 1'b0;
        step();
        check("sq_hold", obs_addr, 16'h0040);
        check("sq_valid", obs_valid, 1'b0);
        run_until_valid("sq_wait");
        check("sq_pc", obs_pc, 16'h0100);

        // halt consumed, then inputs ignored
        k_lat = 0;
        run_until_valid("h_wait");
        k_halt = 1'b1;
        step();
        k_halt = 1'b0;
        step();
        check("h_halted", obs_halted, 1'b1);
        k_redir = 1'b1; k_rpc = 16'h0300;
        step();
        k_redir = 1'b0;
        step();
        check("h_sticky", obs_halted, 1'b1);
        check("h_req", obs_req, 1'b0);

        // redirect and halt together: redirect wins
        do_reset();
        step();
        run_until_valid("rh_wait0");
        k_halt = 1'b1; k_redir = 1'b1; k_rpc = 16'h0200;
        step();
        k_halt = 1'b0; k_redir = 1'b0;
        step();
        check("rh_halted", obs_halted, 1'b0);
        run_until_valid("rh_wait1");
        check("rh_pc", obs_pc, 16'h0200);

        // odd redirect target
        k_redir = 1'b1; k_rpc = 16'h0101;
        step();
        k_redir = 1'b0;
        step();
        check("odd_err", obs_err, 1'b1);
        check("odd_halted", obs_halted, 1'b1);
        do_reset();
        step();
        check("odd_rst_err", obs_err, 1'b0);
        check("odd_rst_halt", obs_halted, 1'b0);
        check("odd_rst_addr", obs_addr, RESET_PC);

        // right-path memory error
        k_inj = 1'b1;
        step();
        k_inj = 1'b0;
        step();
        check("merr_err", obs_err, 1'b1);
        check("merr_halt", obs_halted, 1'b1);

        // PC wrap at 0xFFFE
        do_reset();
        step();
        k_redir = 1'b1; k_rpc = 16'hFFFC;
        step();
        k_redir = 1'b0;
        run_until_valid("wrap_wait");
        check("wrap_pc0", obs_pc, 16'hFFFC);
        step();
        check("wrap_pc2", obs_pc2, 16'h0000);
        step();
        check("wrap_pc1", obs_pc, 16'h0000);
        check("wrap_err", obs_err, 1'b0);

        // randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (sb_halt) do_reset();
            k_stall = ($urandom_range(0, 9) < 3);
            k_redir = ($urandom_range(0, 19) == 0);
            k_halt  = ($urandom_range(0, 59) == 0);
            k_lat   = $urandom_range(0, 3);
            k_rpc   = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 39) == 0) k_rpc[0] = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
